// File: rtl/uart_pkg.sv
// Shared UART definitions: optional-byte request format, frame length and
// the transmit/receive sequencing states.
package uart_pkg;

  localparam int unsigned UART_OPT_BYTE_W = 9;
  localparam int unsigned UART_VALID_BIT  = 8;
  localparam int unsigned UART_FRAME_BITS = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_tx_sched_if.sv
// Byte request channels of the UART transmit scheduler: two requesters,
// each offering a {valid, byte} word and receiving a same-cycle ready.
interface uart_tx_sched_if;
  import uart_pkg::*;

  logic [UART_OPT_BYTE_W-1:0] core_wr_opt_byte;
  logic                       core_wr_ready;
  logic [UART_OPT_BYTE_W-1:0] aux_wr_opt_byte;
  logic                       aux_wr_ready;

  // Requester side: offers bytes, observes acceptance.
  modport master (
    output core_wr_opt_byte,
    output aux_wr_opt_byte,
    input  core_wr_ready,
    input  aux_wr_ready
  );

  // Scheduler side: observes offers, drives acceptance.
  modport slave (
    input  core_wr_opt_byte,
    input  aux_wr_opt_byte,
    output core_wr_ready,
    output aux_wr_ready
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// 8N1 frame sequencer: start bit, eight data bits LSB first, stop bit,
// each held for CLKS_PER_BIT clocks on a registered, idle-high line.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       load,
  input  logic [7:0] data,
  output logic       busy,
  output logic       line
);

  localparam int unsigned            CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]       LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  uart_state_t      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic             r_line;
  logic             w_wrap;

  assign w_wrap = (r_cnt == LAST_CNT);
  assign busy   = (r_state != ST_IDLE);
  assign line   = r_line;

  // Frame sequencing; the line register is loaded with the next bit value
  // on each transition so it lines up with the state it belongs to.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_line  <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (load) begin
            r_shift <= data;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_line  <= 1'b0;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (w_wrap) begin
            r_cnt   <= '0;
            r_line  <= r_shift[0];
            r_state <= ST_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (w_wrap) begin
            r_cnt <= '0;
            if (r_bit == 3'd7) begin
              r_line  <= 1'b1;
              r_state <= ST_STOP;
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_line  <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (w_wrap) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_line  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// UART transmit scheduler: round-robin arbitration between the core and an
// auxiliary byte requester, feeding one 8N1 serializer.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic               CLK,
  input  logic               RST,
  uart_tx_sched_if.slave     wr,
  output logic               uart_line_out,
  output logic               busy,
  output logic               last_grant
);

  logic       r_last_grant;
  logic       w_core_v;
  logic       w_aux_v;
  logic       w_idle;
  logic       w_core_rdy;
  logic       w_aux_rdy;
  logic       w_load;
  logic [7:0] w_data;
  logic       w_busy;

  assign w_core_v = wr.core_wr_opt_byte[UART_VALID_BIT];
  assign w_aux_v  = wr.aux_wr_opt_byte[UART_VALID_BIT];

  // RST gates readiness directly so no byte is accepted while it is asserted.
  assign w_idle     = !w_busy && !RST;
  assign w_core_rdy = w_idle && w_core_v && (!w_aux_v || r_last_grant);
  assign w_aux_rdy  = w_idle && w_aux_v && (!w_core_v || !r_last_grant);
  assign w_load     = w_core_rdy || w_aux_rdy;
  assign w_data     = w_core_rdy ? wr.core_wr_opt_byte[7:0] : wr.aux_wr_opt_byte[7:0];

  assign wr.core_wr_ready = w_core_rdy;
  assign wr.aux_wr_ready  = w_aux_rdy;
  assign busy             = w_busy;
  assign last_grant       = r_last_grant;

  // Remember who was served last; reset favours the core on the first tie.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_last_grant <= 1'b1;
    end else if (w_load) begin
      r_last_grant <= w_aux_rdy;
    end
  end

  uart_tx_serializer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .CLK  (CLK),
    .RST  (RST),
    .load (w_load),
    .data (w_data),
    .busy (w_busy),
    .line (uart_line_out)
  );

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: grant-rule vector table, directed frame
// sequences and random traffic, all against a frame-timeline model.
module tb_uart_tx_sched;
  import uart_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic line, busy, lastg;

  always #5 clk = ~clk;

  uart_tx_sched_if u_if ();

  uart_tx_sched #(.CLKS_PER_BIT(N)) dut (
    .CLK           (clk),
    .RST           (rst),
    .wr            (u_if),
    .uart_line_out (line),
    .busy          (busy),
    .last_grant    (lastg)
  );

  int checks = 0;
  int passed = 0;
  int cyc    = 0;

  // Reference model: one frame timeline defined by its acceptance cycle.
  int       m_T   = 0;
  bit       m_act = 1'b0;
  bit [9:0] m_frame;
  bit       m_last = 1'b1;

  bit         core_pend = 1'b0, aux_pend = 1'b0;
  bit         refill_c = 1'b0, refill_a = 1'b0;
  logic [7:0] core_b = '0, aux_b = '0;
  logic [7:0] acc_q[$];
  int         acc_cyc_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  function automatic bit m_busy();
    return m_act && (cyc > m_T) && (cyc <= m_T + 10 * N);
  endfunction

  function automatic bit m_line();
    if (!m_busy()) return 1'b1;
    return m_frame[(cyc - m_T - 1) / N];
  endfunction

  // One clock cycle: starts 1 time unit after a rising edge, compares on the
  // falling edge, advances the model across the next rising edge.
  task automatic tick(input logic [8:0] c_in, input logic [8:0] a_in,
                      output bit c_acc, output bit a_acc);
    bit idle, ec, ea;
    u_if.core_wr_opt_byte = c_in;
    u_if.aux_wr_opt_byte  = a_in;
    idle = !m_busy();
    ec = idle && c_in[8] && (!a_in[8] || m_last);
    ea = idle && a_in[8] && (!c_in[8] || !m_last);
    @(negedge clk);
    chk("core_ready", u_if.core_wr_ready, ec);
    chk("aux_ready", u_if.aux_wr_ready, ea);
    chk("ready_exclusive", u_if.core_wr_ready & u_if.aux_wr_ready, 0);
    chk("line", line, m_line());
    chk("busy", busy, m_busy());
    chk("last_grant", lastg, m_last);
    if (ec || ea) begin
      m_T     = cyc;
      m_act   = 1'b1;
      m_frame = {1'b1, (ec ? c_in[7:0] : a_in[7:0]), 1'b0};
      m_last  = ea;
      acc_q.push_back(ec ? c_in[7:0] : a_in[7:0]);
      acc_cyc_q.push_back(cyc);
    end
    c_acc = ec;
    a_acc = ea;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Requesters hold valid while a byte is pending; invalid words carry junk.
  task automatic run(input int n);
    logic [8:0] c_in, a_in;
    bit ca, aa;
    for (int i = 0; i < n; i++) begin
      c_in = core_pend ? {1'b1, core_b} : {1'b0, 8'($urandom)};
      a_in = aux_pend ? {1'b1, aux_b} : {1'b0, 8'($urandom)};
      tick(c_in, a_in, ca, aa);
      if (ca && !refill_c) core_pend = 1'b0;
      if (aa && !refill_a) aux_pend = 1'b0;
    end
  endtask

  task automatic do_reset(input int ncyc, input logic [8:0] c_in);
    rst = 1'b1;
    u_if.core_wr_opt_byte = c_in;
    u_if.aux_wr_opt_byte  = '0;
    #1;
    chk("rst_line", line, 1);
    chk("rst_busy", busy, 0);
    chk("rst_core_ready", u_if.core_wr_ready, 0);
    chk("rst_last_grant", lastg, 1);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      chk("rst_hold_ready", {u_if.core_wr_ready, u_if.aux_wr_ready}, 0);
      chk("rst_hold_line", line, 1);
      @(posedge clk);
      #1;
      cyc++;
    end
    rst   = 1'b0;
    m_act = 1'b0;
    m_last = 1'b1;
  endtask

  function automatic logic [31:0] q_at(input int idx);
    return (idx < acc_q.size()) ? 32'(acc_q[idx]) : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] gap(input int a, input int b);
    return (b < acc_cyc_q.size()) ? 32'(acc_cyc_q[b] - acc_cyc_q[a]) : 32'hFFFF_FFFF;
  endfunction

  typedef struct {
    logic [8:0] c;
    logic [8:0] a;
    bit         exp_c;
    bit         exp_a;
    bit         exp_last;
  } vec_t;

  vec_t tbl[6];

  initial begin
    bit ca, aa;
    int t0;
    u_if.core_wr_opt_byte = '0;
    u_if.aux_wr_opt_byte  = '0;

    // Grant rule from reset (last_grant = 1): {core, aux, rdy_c, rdy_a, last after}
    tbl[0] = '{9'h155, 9'h000, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{9'h000, 9'h1AA, 1'b0, 1'b1, 1'b1};
    tbl[2] = '{9'h141, 9'h142, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{9'h0FF, 9'h0FF, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{9'h0FF, 9'h133, 1'b0, 1'b1, 1'b1};
    tbl[5] = '{9'h1C3, 9'h033, 1'b1, 1'b0, 1'b0};

    @(posedge clk);
    #1;

    // Reset values, then a quiet idle period
    do_reset(3, 9'h000);
    for (int i = 0; i < 50; i++) tick(9'h000, 9'h000, ca, aa);

    // Vector table
    for (int i = 0; i < 6; i++) begin
      do_reset(1, 9'h000);
      u_if.core_wr_opt_byte = tbl[i].c;
      u_if.aux_wr_opt_byte  = tbl[i].a;
      @(negedge clk);
      chk($sformatf("tbl%0d_core_ready", i), u_if.core_wr_ready, tbl[i].exp_c);
      chk($sformatf("tbl%0d_aux_ready", i), u_if.aux_wr_ready, tbl[i].exp_a);
      @(posedge clk);
      #1;
      cyc++;
      chk($sformatf("tbl%0d_last_grant", i), lastg, tbl[i].exp_last);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].exp_c | tbl[i].exp_a);
    end
    do_reset(1, 9'h000);

    // Single core byte 0x55, followed by a second byte at the earliest slot
    acc_q.delete(); acc_cyc_q.delete();
    core_pend = 1'b1; core_b = 8'h55;
    run(1);
    core_pend = 1'b1; core_b = 8'h99;
    run(45);
    chk("single_first", q_at(0), 32'h55);
    chk("single_second", q_at(1), 32'h99);
    chk("single_gap", gap(0, 1), 41);
    run(40);

    // Round-robin with both requesters always valid
    do_reset(2, 9'h000);
    acc_q.delete(); acc_cyc_q.delete();
    refill_c = 1'b1; refill_a = 1'b1;
    core_pend = 1'b1; aux_pend = 1'b1; core_b = 8'h41; aux_b = 8'h42;
    run(4 * 41 + 2);
    refill_c = 1'b0; refill_a = 1'b0; core_pend = 1'b0; aux_pend = 1'b0;
    run(45);
    chk("rr_0", q_at(0), 32'h41);
    chk("rr_1", q_at(1), 32'h42);
    chk("rr_2", q_at(2), 32'h41);
    chk("rr_3", q_at(3), 32'h42);

    // No preemption: core requests during bit 3 of an aux frame
    acc_q.delete(); acc_cyc_q.delete();
    aux_pend = 1'b1; aux_b = 8'hA5;
    run(1);
    run(16);
    core_pend = 1'b1; core_b = 8'h3C;
    run(30);
    chk("nopre_aux", q_at(0), 32'hA5);
    chk("nopre_core", q_at(1), 32'h3C);
    chk("nopre_gap", gap(0, 1), 41);
    run(45);

    // Reset during data bit 5 of 0xFF, core byte 0x12 pending throughout
    acc_q.delete(); acc_cyc_q.delete();
    core_pend = 1'b1; core_b = 8'hFF;
    run(1);
    t0 = acc_cyc_q.size() > 0 ? acc_cyc_q[0] : cyc;
    run(24);
    chk("midrst_in_bit5", cyc - t0, 25);
    core_pend = 1'b1; core_b = 8'h12;
    do_reset(2, 9'h112);
    acc_q.delete(); acc_cyc_q.delete();
    run(45);
    chk("midrst_fresh", q_at(0), 32'h12);

    // Invalid requests never accepted
    for (int i = 0; i < 100; i++) tick(9'h0FF, 9'h000, ca, aa);

    // Random traffic, requesters may withdraw before being granted
    for (int i = 0; i < 1500; i++) begin
      if (!core_pend) begin
        if ($urandom_range(0, 7) == 0) begin core_pend = 1'b1; core_b = 8'($urandom); end
      end else if ($urandom_range(0, 15) == 0) core_pend = 1'b0;
      if (!aux_pend) begin
        if ($urandom_range(0, 7) == 0) begin aux_pend = 1'b1; aux_b = 8'($urandom); end
      end else if ($urandom_range(0, 15) == 0) aux_pend = 1'b0;
      run(1);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
